systolic_deskew_collector: RTL
==============================

Name: systolic_deskew_collector

Overview:
- Sits at the output edge of the systolic array. It undoes the input-side skew: lane i of each result row leaves the array i cycles after lane 0.
- Realigns the lanes through per-lane delay lines and writes each aligned row into a small FIFO.
- Presents rows on a valid/ready stream, with a last flag every ROWS rows (one output tile).
- The array cannot stall, so an overflow is flagged, not back-pressured.

Parameters:
- LANES, 4, number of lanes (array columns); must be ≥ 2.
- WIDTH, 8, bits per lane element.
- DEPTH, 4, aligned-row FIFO depth; power of 2, ≥ 2.
- ROWS, 4, rows per tile; sets the out_last period; ≥ 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  row start; qualifies lane 0 in the current cycle.
- in_data  input  LANES*WIDTH  skewed lanes; lane i at bits [i*WIDTH +: WIDTH].
- out_valid  output  1  aligned row available at FIFO head.
- out_ready  input  1  consumer accepts the head row.
- out_data  output  LANES*WIDTH  aligned row, same lane packing as in_data.
- out_last  output  1  head row is the last row of a tile.
- fifo_count  output  $clog2(DEPTH)+1  number of rows stored.
- overflow  output  1  sticky: a row was dropped.

Behaviour:
- Reset: already decided — reset reset, asynchronous, active-high; clock clk. While reset is high, all state clears:
  - out_valid=0, out_data=0, out_last=0, fifo_count=0, overflow=0;
  - all delay registers, valid pipeline, FIFO pointers and row counter = 0.
  - In-flight partial rows are discarded; no write occurs after reset releases.
- Skew contract:
  - If in_valid=1 in cycle t, lane i carries that row's element in cycle t+i.
  - in_valid may be high on consecutive cycles; rows overlap in the lanes.
- Deskew:
  - Lane i passes through LANES-1-i registers; lane LANES-1 is used directly.
  - in_valid passes through LANES-1 registers, giving the aligned write enable.
  - Lane values while their row's valid is low are ignored.
- Latency:
  - For in_valid in cycle t, the FIFO write happens at the end of cycle t+LANES-1.
  - out_valid rises in cycle t+LANES if the FIFO was empty.
  - No combinational path exists from in_* to out_*.
- FIFO: registered, first-in first-out. A pop occurs when out_valid & out_ready.
- Write when full:
  - Without a pop in the same cycle: the row is dropped, overflow is set (sticky until reset), fifo_count stays DEPTH.
  - With a pop in the same cycle: the write is accepted, fifo_count is unchanged, no overflow.
- Simultaneous push and pop (not full): fifo_count is unchanged.
- Pop when empty: not possible, since out_valid=0.
- Pointers wrap modulo DEPTH.
- out_data: equals the head entry when out_valid=1. It is don't-care when out_valid=0, except after reset, when it is 0.
- Row counter:
  - Counts 0..ROWS-1 and increments on each pop, wrapping ROWS-1→0.
  - out_last = out_valid & (row_cnt == ROWS-1).
  - Dropped rows do not advance the counter.
- fifo_count is registered and updates on the same edge as the push/pop.
- State summary:
  - delay lines: LANES-1 stages max;
  - valid pipeline;
  - FIFO storage and read/write pointers;
  - count, row counter, overflow flag.

Test Plan:
- Single row, LANES=4, WIDTH=8, out_ready=1: in_valid in cycle 0; lane i=0x10+i in cycle i, other lanes 0xFF -> cycle 4: out_valid=1, out_data=0x13121110, out_last=0; cycle 5: out_valid=0, fifo_count=0.
- Four back-to-back rows r=0..3, lane i = (r<<4)|i, out_ready=1 -> outputs in cycles 4,5,6,7 = 0x03020100, 0x13121110, 0x23222120, 0x33323130; out_last=1 only in cycle 7; a fifth row then has out_last=0.
- Backpressure: out_ready=0, six consecutive rows -> fifo_count reaches 4; overflow=1 after the 5th row's write edge; rows 4,5 dropped; then out_ready=1 -> rows 0..3 drain in order, out_last on row 3, overflow stays 1.
- Full with concurrent pop: fill to 4, then hold out_ready=1 during a 5th row's write cycle -> overflow=0, fifo_count=4, row 4 emitted after rows 1..3.
- Reset mid-stream: 2 rows stored, 1 row half-deskewed, assert reset for 1 cycle -> all outputs 0 immediately; after release no out_valid ever appears from the in-flight row.
- Noise rejection: in_valid=0 for 20 cycles with random in_data -> out_valid stays 0, fifo_count=0, overflow=0.

Source files
------------

// File: rtl/systolic_deskew_collector.sv
// Output-edge deskew for the systolic array: realigns skewed lanes into whole rows,
// buffers them in a small FIFO and streams them out with a per-tile last flag.
module systolic_deskew_collector #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ROWS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int DW = LANES * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [DW-1:0] aligned;

  // Lane i lags lane 0 by i cycles, so it needs LANES-1-i stages to line up with the last lane.
  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    localparam int D = LANES - 1 - i;
    logic [WIDTH-1:0] dly_q [D];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < D; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= in_data[i*WIDTH +: WIDTH];
        for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign aligned[i*WIDTH +: WIDTH] = dly_q[D-1];
  end

  assign aligned[(LANES-1)*WIDTH +: WIDTH] = in_data[(LANES-1)*WIDTH +: WIDTH];

  logic [LANES-2:0] vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < LANES - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  logic          push, pop, full, accept;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];

  assign push      = vld_q[LANES-2];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == CW'(DEPTH));
  // A full FIFO still takes the row when the head leaves on the same edge.
  assign accept    = push & (~full | pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q | (push & full & ~pop);
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      row_cnt_d = (row_cnt_q == RW'(ROWS - 1)) ? '0 : row_cnt_q + RW'(1);
    end
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: row storage is not reset; out_data is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= aligned;
  end

  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last   = out_valid & (row_cnt_q == RW'(ROWS - 1));
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
